apb_stepper_ctrl: RTL

Parametrised multi-channel stepper pulse generator. It is an APB3 slave on the MSS fabric interface (MSSPSEL/MSSPENABLE/MSSPWRITE/MSSPADDR/MSSPWDATA/MSSPRDATA/MSSPREADY/MSSPSLVERR) and runs in the fabric clock domain. Firmware writes a signed step count per channel, and the block drives STEP/DIR pins with a programmable rate. It tracks each channel's absolute position and raises an interrupt on move completion. It generalises the single-axis plotter driver to NUM_CH axes, with abort, position preload and per-channel IRQ masking.

---
 rtl/apb_stepper_ctrl.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/apb_stepper_ctrl.sv
// APB3 multi-channel stepper pulse generator: per-channel STEP/DIR generation,
// absolute position tracking, abort, position preload and maskable done interrupt.
module apb_stepper_ctrl #(
    parameter int NUM_CH = 2,
    parameter int POS_W  = 24,
    parameter int PER_W  = 16,
    parameter int ADDR_W = 8
) (
    input  logic              SYSCLK,
    input  logic              SYSRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [NUM_CH-1:0] STEP,
    output logic [NUM_CH-1:0] DIR,
    output logic              IRQ
);

    localparam int CH_W = ADDR_W - 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HI   = 2'd1,
        S_LO   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        R_MOVE     = 2'd0,
        R_PERIOD   = 2'd1,
        R_POSITION = 2'd2,
        R_CSR      = 2'd3
    } reg_e;

    logic [CH_W-1:0]   ch_idx;
    reg_e              reg_sel;
    logic              access;
    logic              ch_ok;
    logic              busy_hit;
    logic              err;
    logic              wr_ok;
    logic [NUM_CH-1:0] ch_hit;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] done;
    logic [NUM_CH-1:0] ie;
    logic [POS_W-1:0]  pos_rd [NUM_CH];
    logic [PER_W-1:0]  per_rd [NUM_CH];
    logic              irq_q;
    logic              unused_ok;

    assign ch_idx    = PADDR[ADDR_W-1:4];
    assign reg_sel   = reg_e'(PADDR[3:2]);
    assign access    = PSEL & PENABLE;
    assign unused_ok = ^{PADDR[1:0], PWDATA};

    always_comb begin : decode
        ch_hit = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_hit[c] = (ch_idx == CH_W'(c));
        end
    end

    assign ch_ok    = |ch_hit;
    assign busy_hit = |(busy & ch_hit);

    // Refused accesses (bad channel, MOVE/POSITION while moving) leave every register untouched.
    assign err     = access & (~ch_ok |
                     (PWRITE & ((reg_sel == R_MOVE) | (reg_sel == R_POSITION)) & busy_hit));
    assign wr_ok   = access & PWRITE & ~err;
    assign PSLVERR = err;
    assign PREADY  = 1'b1;

    always_comb begin : read_mux
        PRDATA = '0;
        if (access && !PWRITE) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_hit[c]) begin
                    case (reg_sel)
                        R_PERIOD:   PRDATA = 32'(per_rd[c]);
                        R_POSITION: PRDATA = 32'(signed'(pos_rd[c]));
                        R_CSR:      PRDATA = {28'd0, 1'b0, ie[c], done[c], busy[c]};
                        default:    PRDATA = '0;
                    endcase
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_e           state_q, state_d;
        logic [PER_W-1:0] cnt_q, cnt_d;
        logic [PER_W-1:0] per_q, per_d;
        logic [PER_W-1:0] ph_per_q, ph_per_d;
        logic [POS_W-1:0] rem_q, rem_d;
        logic [POS_W-1:0] pos_q, pos_d;
        logic             dir_q, dir_d;
        logic             done_q, done_d;
        logic             ie_q, ie_d;
        logic             done_set, done_clr;
        logic             wr_sel, move_wr, per_wr, pos_wr, csr_wr, abort_wr;
        logic             phase_end;
        logic [PER_W-1:0] eff_per;
        logic [POS_W-1:0] mv_val, mv_mag;
        logic             step_c, busy_c;

        assign wr_sel   = wr_ok & ch_hit[g];
        assign move_wr  = wr_sel & (reg_sel == R_MOVE);
        assign per_wr   = wr_sel & (reg_sel == R_PERIOD);
        assign pos_wr   = wr_sel & (reg_sel == R_POSITION);
        assign csr_wr   = wr_sel & (reg_sel == R_CSR);
        assign abort_wr = csr_wr & PWDATA[3];

        assign eff_per   = (per_q == '0) ? PER_W'(1) : per_q;
        assign phase_end = (cnt_q == ph_per_q - PER_W'(1));
        assign mv_val    = PWDATA[POS_W-1:0];
        // The most negative count maps onto itself, which read unsigned is the right magnitude.
        assign mv_mag    = mv_val[POS_W-1] ? (POS_W'(0) - mv_val) : mv_val;

        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        always_ff @(posedge SYSCLK) begin : state_reg
            if (SYSRESET) begin
                state_q  <= S_IDLE;
                cnt_q    <= '0;
                per_q    <= PER_W'(1);
                ph_per_q <= PER_W'(1);
                rem_q    <= '0;
                pos_q    <= '0;
                dir_q    <= 1'b1;
                done_q   <= 1'b0;
                ie_q     <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                per_q    <= per_d;
                ph_per_q <= ph_per_d;
                rem_q    <= rem_d;
                pos_q    <= pos_d;
                dir_q    <= dir_d;
                done_q   <= done_d;
                ie_q     <= ie_d;
            end
        end

        // NOTE: every combinational output is defaulted first so no path can infer a latch.
        always_comb begin : next_state
            state_d  = state_q;
            cnt_d    = cnt_q;
            per_d    = per_q;
            ph_per_d = ph_per_q;
            rem_d    = rem_q;
            pos_d    = pos_q;
            dir_d    = dir_q;
            ie_d     = ie_q;
            done_set = 1'b0;
            done_clr = 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (move_wr) begin
                        if (mv_val != '0) begin
                            state_d  = S_HI;
                            cnt_d    = '0;
                            rem_d    = mv_mag;
                            dir_d    = ~mv_val[POS_W-1];
                            ph_per_d = eff_per;
                            done_clr = 1'b1;
                        end else begin
                            done_set = 1'b1;
                        end
                    end
                end
                S_HI: begin
                    if (phase_end) begin
                        state_d  = S_LO;
                        cnt_d    = '0;
                        ph_per_d = eff_per;
                        rem_d    = rem_q - POS_W'(1);
                        pos_d    = dir_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
                    end else begin
                        cnt_d = cnt_q + PER_W'(1);
                    end
                end
                S_LO: begin
                    if (phase_end) begin
                        cnt_d = '0;
                        if (rem_q == '0) begin
                            state_d  = S_IDLE;
                            done_set = 1'b1;
                        end else begin
                            state_d  = S_HI;
                            ph_per_d = eff_per;
                        end
                    end else begin
                        cnt_d = cnt_q + PER_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // Abort drops an in-flight step: position counts only completed high phases.
            if (abort_wr && (state_q != S_IDLE)) begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                rem_d    = rem_q;
                pos_d    = pos_q;
                done_set = 1'b1;
            end

            if (per_wr) per_d = PWDATA[PER_W-1:0];
            if (pos_wr) pos_d = PWDATA[POS_W-1:0];
            if (csr_wr) begin
                ie_d = PWDATA[2];
                if (PWDATA[1]) done_clr = 1'b1;
            end

            done_d = done_set | (done_q & ~done_clr);
        end

        always_comb begin : outputs
            step_c = (state_q == S_HI);
            busy_c = (state_q != S_IDLE);
        end

        assign STEP[g]   = step_c;
        assign DIR[g]    = dir_q;
        assign busy[g]   = busy_c;
        assign done[g]   = done_q;
        assign ie[g]     = ie_q;
        assign pos_rd[g] = pos_q;
        assign per_rd[g] = per_q;
    end

    always_ff @(posedge SYSCLK) begin : irq_reg
        if (SYSRESET) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(done & ie);
        end
    end

    assign IRQ = irq_q;

endmodule
